// File: rtl/hex_segment_decoder_pkg.sv
// Shared types and segment pattern constants for the
// multiplexed seven-segment display monitor.
package hex_segment_decoder_pkg;

    typedef enum logic [1:0] {
        ST_HEX     = 2'b00,
        ST_BLANK   = 2'b01,
        ST_INVALID = 2'b10
    } seg_status_t;

    // Active-high patterns, bit0=a .. bit6=g
    localparam logic [6:0] PAT_0     = 7'h3F;
    localparam logic [6:0] PAT_1     = 7'h06;
    localparam logic [6:0] PAT_2     = 7'h5B;
    localparam logic [6:0] PAT_3     = 7'h4F;
    localparam logic [6:0] PAT_4     = 7'h66;
    localparam logic [6:0] PAT_5     = 7'h6D;
    localparam logic [6:0] PAT_6     = 7'h7D;
    localparam logic [6:0] PAT_7     = 7'h07;
    localparam logic [6:0] PAT_8     = 7'h7F;
    localparam logic [6:0] PAT_9     = 7'h67;
    localparam logic [6:0] PAT_A     = 7'h77;
    localparam logic [6:0] PAT_B     = 7'h7C;
    localparam logic [6:0] PAT_C     = 7'h39;
    localparam logic [6:0] PAT_D     = 7'h5E;
    localparam logic [6:0] PAT_E     = 7'h79;
    localparam logic [6:0] PAT_F     = 7'h71;
    localparam logic [6:0] PAT_BLANK = 7'h00;

endpackage

// File: rtl/hex_segment_decoder_decode.sv
// Combinational seven-segment pattern to nibble/status lookup.
// Non-hex results report value 0.
module seg7_pattern_decode
    import hex_segment_decoder_pkg::*;
(
    input  logic [6:0]  seg,
    output logic [3:0]  value,
    output seg_status_t status
);

    always_comb begin
        value  = 4'h0;
        status = ST_HEX;
        unique case (seg)
            PAT_0:     value = 4'h0;
            PAT_1:     value = 4'h1;
            PAT_2:     value = 4'h2;
            PAT_3:     value = 4'h3;
            PAT_4:     value = 4'h4;
            PAT_5:     value = 4'h5;
            PAT_6:     value = 4'h6;
            PAT_7:     value = 4'h7;
            PAT_8:     value = 4'h8;
            PAT_9:     value = 4'h9;
            PAT_A:     value = 4'hA;
            PAT_B:     value = 4'hB;
            PAT_C:     value = 4'hC;
            PAT_D:     value = 4'hD;
            PAT_E:     value = 4'hE;
            PAT_F:     value = 4'hF;
            PAT_BLANK: status = ST_BLANK;
            default:   status = ST_INVALID;
        endcase
    end

endmodule

// File: rtl/hex_segment_decoder.sv
// Samples a multiplexed 7-segment display, debounces each digit
// and reports per-digit changes through a single-entry event port.
module hex_segment_decoder
    import hex_segment_decoder_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic [NUM_DIGITS-1:0]   invalid_o,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [2:0]              evt_digit,
    output logic [3:0]              evt_value,
    output logic [1:0]              evt_status,
    output logic                    overrun,
    input  logic                    ovr_clr
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [6:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] sel_s1, sel_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            sel_s1 <= '1;
            sel_s2 <= '1;
        end else begin
            seg_s1 <= seg_n;
            seg_s2 <= seg_s1;
            sel_s1 <= dig_sel_n;
            sel_s2 <= sel_s1;
        end
    end

    logic [NUM_DIGITS-1:0] sel;
    logic [3:0]            nlow;
    logic [IW-1:0]         sel_idx;

    assign sel = ~sel_s2;

    always_comb begin
        nlow    = 4'd0;
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                nlow    = nlow + 4'd1;
                sel_idx = IW'(i);
            end
        end
    end

    logic          smp_valid;
    logic [IW-1:0] smp_idx;
    logic [6:0]    smp_pat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_valid <= 1'b0;
            smp_idx   <= '0;
            smp_pat   <= '0;
        end else begin
            smp_valid <= (nlow == 4'd1);
            smp_idx   <= sel_idx;
            smp_pat   <= ~seg_s2;
        end
    end

    logic [IW-1:0] cur_idx;
    logic [6:0]    cand;
    logic [3:0]    cnt;
    logic          committed;
    logic          commit;

    assign commit = (cnt == 4'(STABLE_CYCLES)) && !committed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_idx   <= '0;
            cand      <= '0;
            cnt       <= 4'd0;
            committed <= 1'b0;
        end else if (!smp_valid) begin
            cnt       <= 4'd0;
            committed <= 1'b0;
        end else if (smp_idx == cur_idx && smp_pat == cand) begin
            if (cnt != 4'hF) cnt <= cnt + 4'd1;
            if (commit) committed <= 1'b1;
        end else begin
            cur_idx   <= smp_idx;
            cand      <= smp_pat;
            cnt       <= 4'd1;
            committed <= 1'b0;
        end
    end

    logic [3:0]  dec_value;
    seg_status_t dec_status;

    seg7_pattern_decode u_decode (
        .seg    (cand),
        .value  (dec_value),
        .status (dec_status)
    );

    seg_status_t old_status;
    logic [3:0]  old_value;
    logic        changed;
    logic        xfer;
    logic        load_evt;
    logic        drop_evt;

    assign old_status = seg_status_t'({invalid_o[cur_idx], blank_o[cur_idx]});
    assign old_value  = digits_o[{cur_idx, 2'b00} +: 4];
    assign changed    = commit &&
                        (old_status != dec_status || old_value != dec_value);
    assign xfer       = evt_valid && evt_ready;
    assign load_evt   = changed && (!evt_valid || xfer);
    assign drop_evt   = changed && evt_valid && !xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_o  <= '0;
            blank_o   <= '1;
            invalid_o <= '0;
        end else if (changed) begin
            digits_o[{cur_idx, 2'b00} +: 4] <= dec_value;
            blank_o[cur_idx]   <= (dec_status == ST_BLANK);
            invalid_o[cur_idx] <= (dec_status == ST_INVALID);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid  <= 1'b0;
            evt_digit  <= 3'd0;
            evt_value  <= 4'd0;
            evt_status <= 2'b00;
        end else if (load_evt) begin
            evt_valid  <= 1'b1;
            evt_digit  <= 3'(cur_idx);
            evt_value  <= dec_value;
            evt_status <= dec_status;
        end else if (xfer) begin
            evt_valid  <= 1'b0;
        end
    end

    // A drop wins over a same-edge clear so no loss goes unreported
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        overrun <= 1'b0;
        else if (drop_evt) overrun <= 1'b1;
        else if (ovr_clr)  overrun <= 1'b0;
    end

endmodule

// File: doc/hex_segment_decoder.md
HEX_SEGMENT_DECODER -- requirements
Module: hex_segment_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed display digits monitored (2..8).
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a pattern is committed (1..15).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 seg_n  input  7  active-low segment lines, bit0=a .. bit6=g, asynchronous to clk.
REQ-006 dig_sel_n  input  NUM_DIGITS  active-low digit strobes, asynchronous to clk.
REQ-007 digits_o  output  4*NUM_DIGITS  last committed nibble per digit, digit i at bits [4i+3:4i].
REQ-008 blank_o  output  NUM_DIGITS  digit i currently shows all-segments-off.
REQ-009 invalid_o  output  NUM_DIGITS  digit i currently shows a non-hex pattern.
REQ-010 evt_valid  output  1  change event available.
REQ-011 evt_ready  input  1  consumer accepts event.
REQ-012 evt_digit  output  3  digit index of event.
REQ-013 evt_value  output  4  decoded nibble of event (0 when status is not HEX).
REQ-014 evt_status  output  2  00 HEX, 01 BLANK, 10 INVALID.
REQ-015 overrun  output  1  sticky: an event was dropped.
REQ-016 ovr_clr  input  1  synchronous clear of overrun.

Function
REQ-017 seg_n and dig_sel_n SHALL pass through a 2-flop synchronizer before any use.
REQ-018 Segments SHALL be inverted to active-high, then decoded: 3F-0, 06-1, 5B-2, 4F-3, 66-4, 6D-5, 7D-6, 07-7, 7F-8, 67-9, 77-A, 7C-B, 39-C, 5E-D, 79-E, 71-F, 00-BLANK, any other-INVALID.
REQ-019 A sample is qualified only when synchronized dig_sel_n has exactly one bit low; zero or multiple low bits SHALL reset the stability counter and clear the window-committed flag.
REQ-020 Tracker state: current digit index, candidate pattern, 4-bit saturating count, committed flag.
REQ-021 Qualified sample with same digit and pattern as candidate SHALL increment count (saturating); otherwise candidate loads, count=1, committed flag clears.
REQ-022 When count reaches STABLE_CYCLES and committed flag clear, SHALL commit once: set committed flag; if decoded result differs from stored digit state, update digits_o/blank_o/invalid_o for that digit and post an event.
REQ-023 A commit identical to stored state SHALL NOT post an event.
REQ-024 Latency: pins stable from before edge 0 -> evt_valid high after edge 2+STABLE_CYCLES+1 (7 at default); digits_o updates on the same edge.
REQ-025 Event holding register is single-entry; evt_* stable while evt_valid high and evt_ready low.
REQ-026 Transfer occurs on an edge with evt_valid and evt_ready high; evt_valid then falls unless a new event loads on that same edge.
REQ-027 Commit with register full and no transfer that edge: digit state still updates, event dropped, overrun set.
REQ-028 Commit coinciding with transfer: new event loads, evt_valid stays high, no overrun.
REQ-029 ovr_clr and a new overrun on the same edge: overrun remains set.

Reset
REQ-030 On rst_n low: synchronizers 1s, digits_o 0, blank_o all 1, invalid_o 0, evt_valid 0, evt_* 0, overrun 0, count 0, committed flag 0.
REQ-031 Reset mid-window SHALL discard partial stability count; a pending event is lost without setting overrun.

Structure
REQ-032 Package hex_segment_decoder_pkg SHALL hold status encoding (HEX/BLANK/INVALID) and the 17 segment pattern constants.
REQ-033 Combinational lookup SHALL be sub-module seg7_pattern_decode (7-bit active-high in, 4-bit value plus 2-bit status out).
REQ-034 Digit index width SHALL be clog2(NUM_DIGITS), zero-extended onto evt_digit.

Verification
REQ-035 After reset, dig_sel_n=8'hFE, seg_n=~7'h5B held -> evt_valid at edge 7, evt_digit 0, evt_value 2, status HEX; digits_o[3:0]=2, blank_o[0]=0.
REQ-036 Same pattern held 100 cycles, evt_ready=1 -> exactly one event.
REQ-037 dig_sel_n=8'hFB, seg_n=~7'h49 -> event digit 2, status INVALID, invalid_o[2]=1; then seg_n=~7'h00 -> status BLANK, blank_o[2]=1, invalid_o[2]=0.
REQ-038 Glitch: pattern ~7'h06 held 3 cycles then ~7'h07 (STABLE_CYCLES=4) -> no event for 1; event value 7 after 4 stable samples.
REQ-039 evt_ready=0, two digit changes committed -> first event held unchanged, overrun=1, digits_o shows both; ovr_clr clears overrun.
REQ-040 dig_sel_n=8'hFC (two low) for 20 cycles -> no event, no state change; rst_n pulsed mid-window -> outputs at reset values.
